// File: rtl/bit_timer_pkg.sv
// Shared types and default parameter values for the bit sample timer.
package bit_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_OSR           = 16;
    localparam int DEF_BITS_PER_CHAR = 10;
    localparam int DEF_SAMPLE_POINT  = 7;

endpackage

// File: rtl/bit_sample_timer_if.sv
// Control/status bundle of the bit sample timer: the frame enable and the
// counters and pulses that report bit timing.
interface bit_sample_timer_if
#(
    parameter int OSR           = bit_timer_pkg::DEF_OSR,
    parameter int BITS_PER_CHAR = bit_timer_pkg::DEF_BITS_PER_CHAR
);
    import bit_timer_pkg::*;

    localparam int SCW = $clog2(OSR);
    localparam int BCW = $clog2(BITS_PER_CHAR + 1);

    logic           enable;
    logic [SCW-1:0] sample_cnt;
    logic [BCW-1:0] bit_cnt;
    logic           shift_strobe;
    logic           bit_done;
    logic           char_done;
    logic           busy;

    modport master (
        output enable,
        input  sample_cnt, bit_cnt, shift_strobe, bit_done, char_done, busy
    );

    modport slave (
        input  enable,
        output sample_cnt, bit_cnt, shift_strobe, bit_done, char_done, busy
    );

endinterface

// File: rtl/bit_sample_timer_mod_n_counter.sv
// Modulo-N counter with synchronous clear; wrap_o flags the increment that
// rolls the count from N-1 back to 0.
module mod_n_counter
#(
    parameter int MODULUS = 2,
    parameter int WIDTH   = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    if (MODULUS < 1) begin : g_bad_modulus
        $error("mod_n_counter: MODULUS must be at least 1");
    end
    if (WIDTH < 1 || (MODULUS - 1) >= (2 ** WIDTH)) begin : g_bad_width
        $error("mod_n_counter: WIDTH too small for MODULUS-1");
    end

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign wrap_o  = inc_i && (count_q == LAST);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = wrap_o ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bit_sample_timer.sv
// Oversampled bit/character timer: counts OSR clocks per bit and
// BITS_PER_CHAR bits per character, emitting sample and completion pulses.
module bit_sample_timer
    import bit_timer_pkg::*;
#(
    parameter int OSR           = DEF_OSR,
    parameter int BITS_PER_CHAR = DEF_BITS_PER_CHAR,
    parameter int SAMPLE_POINT  = DEF_SAMPLE_POINT
)
(
    input  logic                 clk,
    input  logic                 rst,
    bit_sample_timer_if.slave    bus
);

    localparam int SCW = $clog2(OSR);
    localparam int BCW = $clog2(BITS_PER_CHAR + 1);

    if (OSR < 2 || OSR > 256) begin : g_bad_osr
        $error("bit_sample_timer: OSR must be in 2..256");
    end
    if (BITS_PER_CHAR < 1 || BITS_PER_CHAR > 32) begin : g_bad_bpc
        $error("bit_sample_timer: BITS_PER_CHAR must be in 1..32");
    end
    if (SAMPLE_POINT < 0 || SAMPLE_POINT > OSR - 1) begin : g_bad_sp
        $error("bit_sample_timer: SAMPLE_POINT must be in 0..OSR-1");
    end

    state_e         state_q;
    logic           busy_q;
    logic           counting;
    logic           runCount;
    logic [SCW-1:0] sampleCnt;
    logic [BCW-1:0] bitCnt;
    logic           sampleWrap;
    logic           bitWrap;
    logic           bitDone;

    assign counting = (state_q == COUNT);
    assign runCount = counting && bus.enable;

    // Counters are held at zero whenever the frame is not actively running,
    // so IDLE, DONE and an abort all leave them cleared.
    mod_n_counter #(.MODULUS(OSR), .WIDTH(SCW)) u_sample_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (!runCount),
        .inc_i   (runCount),
        .count_o (sampleCnt),
        .wrap_o  (sampleWrap)
    );

    mod_n_counter #(.MODULUS(BITS_PER_CHAR), .WIDTH(BCW)) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (!runCount),
        .inc_i   (sampleWrap),
        .count_o (bitCnt),
        .wrap_o  (bitWrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        state_q <= COUNT;
                        busy_q  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (!bus.enable || bitWrap) begin
                        state_q <= bus.enable ? DONE : IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (!bus.enable) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bitDone          = counting && (sampleCnt == SCW'(OSR - 1));
    assign bus.shift_strobe = counting && (sampleCnt == SCW'(SAMPLE_POINT));
    assign bus.bit_done     = bitDone;
    assign bus.char_done    = bitDone && (bitCnt == BCW'(BITS_PER_CHAR - 1));
    assign bus.busy         = busy_q;
    assign bus.sample_cnt   = sampleCnt;
    assign bus.bit_cnt      = bitCnt;

endmodule

// File: tb/tb_bit_sample_timer.sv
// Randomized and directed bench for bit_sample_timer: three parameter sets
// run side by side against a frame-position reference model.
module tb_bit_sample_timer;
    import bit_timer_pkg::*;

    localparam int N = 3;
    localparam int OSR0 = 16, BPC0 = 10, SP0 = 7;
    localparam int OSR1 = 4,  BPC1 = 1,  SP1 = 3;
    localparam int OSR2 = 5,  BPC2 = 3,  SP2 = 2;

    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;

    logic clk = 1'b0;
    logic rst;
    logic en [N];

    always #5 clk = ~clk;

    bit_sample_timer_if #(.OSR(OSR0), .BITS_PER_CHAR(BPC0)) bus0 ();
    bit_sample_timer_if #(.OSR(OSR1), .BITS_PER_CHAR(BPC1)) bus1 ();
    bit_sample_timer_if #(.OSR(OSR2), .BITS_PER_CHAR(BPC2)) bus2 ();

    assign bus0.enable = en[0];
    assign bus1.enable = en[1];
    assign bus2.enable = en[2];

    bit_sample_timer #(.OSR(OSR0), .BITS_PER_CHAR(BPC0), .SAMPLE_POINT(SP0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    bit_sample_timer #(.OSR(OSR1), .BITS_PER_CHAR(BPC1), .SAMPLE_POINT(SP1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    bit_sample_timer #(.OSR(OSR2), .BITS_PER_CHAR(BPC2), .SAMPLE_POINT(SP2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int osrT [N] = '{OSR0, OSR1, OSR2};
    int bpcT [N] = '{BPC0, BPC1, BPC2};
    int spT  [N] = '{SP0,  SP1,  SP2};

    logic [31:0] obsCnt [N];
    logic [31:0] obsBit [N];
    logic [31:0] obsStb [N];
    logic [31:0] obsBd  [N];
    logic [31:0] obsCd  [N];
    logic [31:0] obsBusy[N];

    always_comb begin
        obsCnt[0] = 32'(bus0.sample_cnt); obsBit[0] = 32'(bus0.bit_cnt);
        obsStb[0] = 32'(bus0.shift_strobe); obsBd[0] = 32'(bus0.bit_done);
        obsCd[0]  = 32'(bus0.char_done);   obsBusy[0] = 32'(bus0.busy);
        obsCnt[1] = 32'(bus1.sample_cnt); obsBit[1] = 32'(bus1.bit_cnt);
        obsStb[1] = 32'(bus1.shift_strobe); obsBd[1] = 32'(bus1.bit_done);
        obsCd[1]  = 32'(bus1.char_done);   obsBusy[1] = 32'(bus1.busy);
        obsCnt[2] = 32'(bus2.sample_cnt); obsBit[2] = 32'(bus2.bit_cnt);
        obsStb[2] = 32'(bus2.shift_strobe); obsBd[2] = 32'(bus2.bit_done);
        obsCd[2]  = 32'(bus2.char_done);   obsBusy[2] = 32'(bus2.busy);
    end

    // Reference model: a frame is a run of OSR*BITS_PER_CHAR clocks; pos is
    // the clock index inside it, so sample/bit follow from division.
    int mode [N];
    int pos  [N];
    int cyc;
    int compared;
    int mismatched;

    bit watch;
    int wBase, wStbN, wBdN, wCdN, wFirstStb, wCdRel, wBusy161, wTriple1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e0, input logic e1, input logic e2);
        rst   = r;
        en[0] = e0;
        en[1] = e1;
        en[2] = e2;
    endtask

    task automatic modelUpdate();
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                mode[k] = M_IDLE;
                pos[k]  = 0;
            end else if (mode[k] == M_IDLE) begin
                if (en[k]) begin
                    mode[k] = M_RUN;
                    pos[k]  = 0;
                end
            end else if (mode[k] == M_RUN) begin
                if (!en[k]) begin
                    mode[k] = M_IDLE;
                    pos[k]  = 0;
                end else if (pos[k] == osrT[k] * bpcT[k] - 1) begin
                    mode[k] = M_HOLD;
                    pos[k]  = 0;
                end else begin
                    pos[k]++;
                end
            end else if (!en[k]) begin
                mode[k] = M_IDLE;
            end
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < N; k++) begin
            bit run = (mode[k] == M_RUN);
            int sc  = pos[k] % osrT[k];
            int bt  = pos[k] / osrT[k];
            checkOutput($sformatf("u%0d_sample_cnt", k), obsCnt[k], run ? sc : 0);
            checkOutput($sformatf("u%0d_bit_cnt", k), obsBit[k], run ? bt : 0);
            checkOutput($sformatf("u%0d_shift_strobe", k), obsStb[k], 32'(run && sc == spT[k]));
            checkOutput($sformatf("u%0d_bit_done", k), obsBd[k], 32'(run && sc == osrT[k] - 1));
            checkOutput($sformatf("u%0d_char_done", k), obsCd[k],
                        32'(run && pos[k] == osrT[k] * bpcT[k] - 1));
            checkOutput($sformatf("u%0d_busy", k), obsBusy[k], 32'(run));
        end
        if (watch) begin
            int rel = cyc - wBase;
            if (obsStb[0] != 0) begin
                wStbN++;
                if (wFirstStb < 0) wFirstStb = rel;
            end
            if (obsBd[0] != 0) wBdN++;
            if (obsCd[0] != 0) begin
                wCdN++;
                if (wCdRel < 0) wCdRel = rel;
            end
            if (rel == 161) wBusy161 = int'(obsBusy[0]);
            if (wTriple1 < 0 && obsStb[1] != 0 && obsBd[1] != 0 && obsCd[1] != 0) wTriple1 = rel;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        cyc++;
        modelUpdate();
        #1;
        checkAll();
    endtask

    task automatic startWatch();
        watch     = 1'b1;
        wBase     = cyc;
        wStbN     = 0;
        wBdN      = 0;
        wCdN      = 0;
        wFirstStb = -1;
        wCdRel    = -1;
        wBusy161  = -1;
        wTriple1  = -1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        watch      = 1'b0;
        for (int k = 0; k < N; k++) begin
            mode[k] = M_IDLE;
            pos[k]  = 0;
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) stepCycle();

        // Reset must win over enable.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        stepCycle();
        checkOutput("rst_over_enable_busy", obsBusy[0], 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();

        // Full default frame with enable held from cycle 0.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        startWatch();
        repeat (170) stepCycle();
        checkOutput("frame_first_strobe", wFirstStb, 8);
        checkOutput("frame_strobe_count", wStbN, 10);
        checkOutput("frame_bitdone_count", wBdN, 10);
        checkOutput("frame_chardone_count", wCdN, 1);
        checkOutput("frame_chardone_cycle", wCdRel, 160);
        checkOutput("frame_busy_after", wBusy161, 0);
        checkOutput("osr4_bpc1_triple_cycle", wTriple1, 4);
        watch = 1'b0;

        // Hold in DONE, then restart after a one-cycle enable drop.
        repeat (50) stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        startWatch();
        repeat (20) stepCycle();
        checkOutput("restart_first_strobe", wFirstStb, 8);
        watch = 1'b0;

        // Abort mid-frame at bit 4, sample 9.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 400 && !(mode[0] == M_RUN && pos[0] == 4 * OSR0 + 9); i++) stepCycle();
        checkOutput("abort_pre_bit", obsBit[0], 4);
        checkOutput("abort_pre_sample", obsCnt[0], 9);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        startWatch();
        stepCycle();
        checkOutput("abort_busy", obsBusy[0], 0);
        checkOutput("abort_sample", obsCnt[0], 0);
        checkOutput("abort_bit", obsBit[0], 0);
        repeat (5) stepCycle();
        checkOutput("abort_no_chardone", wCdN, 0);
        watch = 1'b0;

        // Reset at bit 9, sample 14 discards the frame.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 400 && !(mode[0] == M_RUN && pos[0] == 9 * OSR0 + 14); i++) stepCycle();
        checkOutput("rst_pre_bit", obsBit[0], 9);
        checkOutput("rst_pre_sample", obsCnt[0], 14);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        startWatch();
        stepCycle();
        checkOutput("rst_mid_busy", obsBusy[0], 0);
        checkOutput("rst_mid_sample", obsCnt[0], 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) stepCycle();
        checkOutput("rst_mid_no_chardone", wCdN, 0);
        watch = 1'b0;

        // Randomized enables with occasional reset pulses.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 39) == 0) en[k] = !en[k];
            end
            stepCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bit_sample_timer.md
BIT_SAMPLE_TIMER -- requirements
Module: bit_sample_timer

Interface
REQ-001 The block SHALL have parameter OSR, default 16: oversample clocks per bit, legal range 2..256.
REQ-002 The block SHALL have parameter BITS_PER_CHAR, default 10: bits per character, legal range 1..32.
REQ-003 The block SHALL have parameter SAMPLE_POINT, default 7: the sample_cnt value at which shift_strobe fires, legal range 0..OSR-1.
REQ-004 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port enable  input  1: 1 runs or holds a character frame; 0 aborts or idles.
REQ-007 Port sample_cnt  output  $clog2(OSR): current oversample count within the bit.
REQ-008 Port bit_cnt  output  $clog2(BITS_PER_CHAR+1): index of the current bit within the character.
REQ-009 Port shift_strobe  output  1: one-cycle pulse at the bit sample point.
REQ-010 Port bit_done  output  1: one-cycle pulse in the last oversample cycle of each bit.
REQ-011 Port char_done  output  1: one-cycle pulse in the last oversample cycle of the last bit.
REQ-012 Port busy  output  1: high while in state COUNT.

Function
REQ-013 The block SHALL implement states IDLE, COUNT and DONE, all registered.
REQ-014 IDLE: on an edge with enable=1, the block SHALL go to COUNT with sample_cnt=0 and bit_cnt=0; otherwise it SHALL stay in IDLE.
REQ-015 COUNT with enable=1: the block SHALL increment sample_cnt each edge, wrapping OSR-1 to 0.
REQ-016 On that wrap, the block SHALL increment bit_cnt.
REQ-017 COUNT with enable=0: the block SHALL abort to IDLE on the next edge and clear both counters, with no char_done.
REQ-018 The wrap edge with bit_cnt=BITS_PER_CHAR-1 SHALL go to DONE with both counters cleared to 0.
REQ-019 DONE: the block SHALL hold counters at 0 while enable=1, and SHALL go to IDLE on the first edge with enable=0.
REQ-020 A new frame SHALL therefore require enable to drop for at least one cycle.
REQ-021 shift_strobe SHALL equal (state==COUNT && sample_cnt==SAMPLE_POINT), decoded combinationally from registered state with zero latency.
REQ-022 bit_done SHALL equal (state==COUNT && sample_cnt==OSR-1).
REQ-023 char_done SHALL equal (bit_done && bit_cnt==BITS_PER_CHAR-1).
REQ-024 When SAMPLE_POINT==OSR-1, shift_strobe and bit_done SHALL assert in the same cycle.
REQ-025 When BITS_PER_CHAR==1, each char_done SHALL coincide with the single bit_done of the frame.
REQ-026 busy SHALL be 1 only in COUNT.
REQ-027 In IDLE and DONE, sample_cnt and bit_cnt SHALL read 0 and all pulses SHALL be 0.
REQ-028 Counter widths SHALL hold OSR-1 and BITS_PER_CHAR-1 without overflow.
REQ-029 Increments SHALL be computed at the counter width, with no implicit truncation warnings.
REQ-030 Illegal parameter values SHALL be rejected at elaboration with an error.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, sample_cnt=0 and bit_cnt=0 from any state.
REQ-032 rst SHALL take priority over enable.
REQ-033 During and after reset, shift_strobe, bit_done, char_done and busy SHALL all be 0.
REQ-034 Reset asserted mid-frame SHALL discard the frame, with no char_done.

Structure
REQ-035 Package bit_timer_pkg SHALL hold the state enum type (IDLE, COUNT, DONE) and default parameter constants.
REQ-036 One sub-module mod_n_counter SHALL provide the count; it is parametrised by modulus and has clear, inc and wrap outputs.
REQ-037 mod_n_counter SHALL be instantiated twice: oversample counter and bit counter.
REQ-038 The FSM SHALL reside in bit_sample_timer.

Verification
REQ-039 Defaults, enable=1 held from cycle 0 -> busy=1 from cycle 1; shift_strobe at cycles 8, 24, ..., 152; bit_done at cycles 16, 32, ..., 160; char_done only at cycle 160; busy=0 from cycle 161.
REQ-040 Defaults, enable held high after char_done for 50 cycles -> no pulses and counters 0; enable low one cycle then high -> new frame with first shift_strobe 8 cycles after re-entry.
REQ-041 Defaults, enable dropped when bit_cnt=4 and sample_cnt=9 -> next cycle IDLE, counters 0, no char_done.
REQ-042 rst pulsed when bit_cnt=9 and sample_cnt=14 -> IDLE, counters 0, char_done never asserts for that frame.
REQ-043 OSR=4, BITS_PER_CHAR=1, SAMPLE_POINT=3 -> shift_strobe, bit_done and char_done all high together 4 cycles after entering COUNT.
REQ-044 Simultaneous rst=1 and enable=1 from IDLE -> remains IDLE, busy=0.
